control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter NUM_REGS, default 4, number of data registers D0..D(NUM_REGS-1); legal range 1..16.
REQ-002 Parameter SEL_W, default 2, width of register-select field; SHALL equal max(1, clog2(NUM_REGS)).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 opcode  input  4  opcode field from IR, valid from the cycle after fetch T2.
REQ-006 reg_sel  input  SEL_W  register-select field from IR, same timing as opcode.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory handshake; high = read data valid / write accepted this cycle.
REQ-009 oe_ms, oe_ir, oe_pc, oe_alureg  output  1 each  bus output enables.
REQ-010 oe_d  output  NUM_REGS  one-hot output enable per data register.
REQ-011 we_mar, we_ir, we_pc, we_alureg  output  1 each  register write enables.
REQ-012 we_d  output  NUM_REGS  one-hot write enable per data register.
REQ-013 func  output  2  ALU function: 00 zero, 01 inc, 10 add, 11 dec.
REQ-014 read, write  output  1 each  memory strobes.
REQ-015 state  output  2  00 FETCH, 01 EXECUTE, 10 HALTED.
REQ-016 phase  output  3  current step, 1..5 encodes T1..T5.
REQ-017 halted, illegal  output  1 each  status flags.

Function
REQ-018 Outputs SHALL be combinational decodes of registered state, phase, latched opcode/reg_sel, zero and mem_ready; any output not asserted by a step SHALL be 0.
REQ-019 Phase SHALL advance by one per cycle, except a step asserting read or write SHALL hold while mem_ready=0 (wait state).
REQ-020 FETCH: T1 oe_pc,we_mar; T2 read,oe_ms, we_ir only when mem_ready=1; T3 oe_pc,func=01,we_alureg; T4 oe_alureg,we_pc; T5 no strobes, latch opcode and reg_sel, go EXECUTE T1.
REQ-021 Rd = one-hot of latched reg_sel; reg_sel >= NUM_REGS SHALL set illegal and execute as NOP.
REQ-022 CLEAR(0): T1 func=00,we_alureg; T2 oe_alureg,we_d[Rd]; T3 return.
REQ-023 INC(1)/DEC(3): T1 oe_d[Rd], func=01/11, we_alureg; T2 oe_alureg,we_d[Rd]; T3 return.
REQ-024 ADD(2): T1 oe_ir,func=10,we_alureg; T2 oe_alureg,we_d[Rd]; T3 return.
REQ-025 JMP(4): T1 oe_ir,we_pc; T2 return. BUZ(5): T1 oe_ir,we_pc only if zero=1; T2 return.
REQ-026 LOAD(6): T1 oe_ir,we_mar; T2 read,oe_ms, we_d[Rd] only when mem_ready=1; T3 return.
REQ-027 STORE(7): T1 oe_ir,we_mar; T2 oe_d[Rd],write (held until mem_ready=1); T3 return.
REQ-028 HALT(8): T1 enter HALTED; HALTED asserts halted=1, all strobes 0, exits only by reset.
REQ-029 Opcodes 9..15: illegal=1 during EXECUTE T1, no strobes, T2 return.
REQ-030 "Return" step asserts no strobes and next cycle is FETCH T1; illegal clears on return.
REQ-031 At most one oe_* / oe_d bit SHALL be high in any cycle.

Reset
REQ-032 rst_n=0 at a clock edge SHALL set state=FETCH, phase=1, latched opcode/reg_sel=0, halted=0, illegal=0, including mid-wait-state and from HALTED.
REQ-033 While rst_n=0 all outputs except state/phase SHALL be forced 0.

Verification
REQ-034 Reset release, mem_ready=1, opcode=0 reg_sel=2 -> 5 fetch cycles then we_d=0100 at EXECUTE T2, back to FETCH T1 on cycle 9.
REQ-035 FETCH T2 with mem_ready=0 for 3 cycles -> read held 4 cycles, we_ir pulses only in 4th, phase stays 2.
REQ-036 BUZ with zero=0 -> we_pc never high in EXECUTE; zero=1 -> we_pc=1 at EXECUTE T1.
REQ-037 NUM_REGS=3, reg_sel=3 with INC -> illegal=1, we_d=000 throughout, next fetch normal.
REQ-038 HALT -> halted=1 and all strobes 0 for 20 cycles; rst_n low one cycle -> FETCH T1, halted=0.
REQ-039 STORE with mem_ready low, rst_n pulsed mid-wait -> write drops, next fetch starts at T1.

Source files
------------

// File: rtl/control_sequencer.sv
// Purpose: microcoded control sequencer, FETCH T1..T5 then EXECUTE T1..Tn per opcode.
// Latency: every output is a combinational decode of the registered step; the step advances once per clk.
// Backpressure: a step that drives read or write holds while mem_ready=0; HALTED is left only through reset.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   opcode, reg_sel        IR fields, latched at FETCH T5
//   zero, mem_ready        ALU zero flag, memory handshake
//   oe_*, oe_d             bus output enables (at most one high per cycle)
//   we_*, we_d             register write enables
//   func                   ALU function (00 zero, 01 inc, 10 add, 11 dec)
//   read, write            memory strobes
//   state, phase           00 FETCH / 01 EXECUTE / 10 HALTED, step 1..5
//   halted, illegal        status flags
module control_sequencer #(
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          opcode,
    input  logic [SEL_W-1:0]    reg_sel,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                oe_ms,
    output logic                oe_ir,
    output logic                oe_pc,
    output logic                oe_alureg,
    output logic [NUM_REGS-1:0] oe_d,
    output logic                we_mar,
    output logic                we_ir,
    output logic                we_pc,
    output logic                we_alureg,
    output logic [NUM_REGS-1:0] we_d,
    output logic [1:0]          func,
    output logic                read,
    output logic                write,
    output logic [1:0]          state,
    output logic [2:0]          phase,
    output logic                halted,
    output logic                illegal
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_e;

    // All strobes in one bundle so a single '0 clears every one of them.
    typedef struct packed {
        logic                oe_ms;
        logic                oe_ir;
        logic                oe_pc;
        logic                oe_alureg;
        logic [NUM_REGS-1:0] oe_d;
        logic                we_mar;
        logic                we_ir;
        logic                we_pc;
        logic                we_alureg;
        logic [NUM_REGS-1:0] we_d;
        logic [1:0]          func;
        logic                read;
        logic                write;
    } ctl_t;

    localparam logic [SEL_W:0] NREGS_CMP = (SEL_W+1)'(NUM_REGS);

    state_e            state_q, state_d;
    logic [2:0]        phase_q, phase_d;
    logic [3:0]        op_q, op_d;
    logic [SEL_W-1:0]  sel_q, sel_d;

    ctl_t                ctl;
    logic [NUM_REGS-1:0] rd_oh;
    logic                sel_ok;
    logic                uses_rd;
    logic                ret;
    logic                jump;
    logic                halted_c;
    logic                illegal_c;

    always_comb begin
        rd_oh = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_oh[i] = (sel_q == SEL_W'(i));
        end
    end

    assign sel_ok  = {1'b0, sel_q} < NREGS_CMP;
    assign uses_rd = (op_q <= 4'd3) || (op_q == 4'd6) || (op_q == 4'd7);

    always_comb begin
        ctl       = '0;
        halted_c  = 1'b0;
        illegal_c = 1'b0;
        ret       = 1'b0;
        jump      = 1'b0;
        state_d   = state_q;
        phase_d   = phase_q;
        op_d      = op_q;
        sel_d     = sel_q;

        case (state_q)
            ST_FETCH: begin
                case (phase_q)
                    3'd1: begin ctl.oe_pc = 1'b1; ctl.we_mar = 1'b1; end
                    3'd2: begin ctl.read = 1'b1; ctl.oe_ms = 1'b1; ctl.we_ir = mem_ready; end
                    3'd3: begin ctl.oe_pc = 1'b1; ctl.func = 2'b01; ctl.we_alureg = 1'b1; end
                    3'd4: begin ctl.oe_alureg = 1'b1; ctl.we_pc = 1'b1; end
                    3'd5: begin
                        jump    = 1'b1;
                        state_d = ST_EXEC;
                        phase_d = 3'd1;
                        op_d    = opcode;
                        sel_d   = reg_sel;
                    end
                    default: ret = 1'b1;
                endcase
            end
            ST_EXEC: begin
                case (op_q)
                    4'd0, 4'd1, 4'd2, 4'd3: begin
                        case (phase_q)
                            3'd1: begin
                                ctl.we_alureg = 1'b1;
                                ctl.func      = op_q[1:0];
                                // CLEAR needs no operand; INC/DEC read Rd, ADD reads the IR immediate.
                                if (op_q == 4'd2) ctl.oe_ir = 1'b1;
                                else if (op_q != 4'd0) ctl.oe_d = rd_oh;
                            end
                            3'd2: begin ctl.oe_alureg = 1'b1; ctl.we_d = rd_oh; end
                            default: ret = 1'b1;
                        endcase
                    end
                    4'd4, 4'd5: begin
                        if (phase_q == 3'd1) begin
                            ctl.oe_ir = 1'b1;
                            ctl.we_pc = (op_q == 4'd4) || zero;
                        end else begin
                            ret = 1'b1;
                        end
                    end
                    4'd6, 4'd7: begin
                        case (phase_q)
                            3'd1: begin ctl.oe_ir = 1'b1; ctl.we_mar = 1'b1; end
                            3'd2: begin
                                if (op_q == 4'd6) begin
                                    ctl.read  = 1'b1;
                                    ctl.oe_ms = 1'b1;
                                    ctl.we_d  = mem_ready ? rd_oh : '0;
                                end else begin
                                    ctl.oe_d  = rd_oh;
                                    ctl.write = 1'b1;
                                end
                            end
                            default: ret = 1'b1;
                        endcase
                    end
                    4'd8: begin
                        if (phase_q == 3'd1) begin
                            jump    = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            ret = 1'b1;
                        end
                    end
                    default: begin
                        if (phase_q == 3'd1) illegal_c = 1'b1;
                        else                 ret       = 1'b1;
                    end
                endcase
                // Out-of-range Rd: keep the opcode's step count but drive nothing,
                // flagging illegal until the return step.
                if (uses_rd && !sel_ok && !ret) begin
                    ctl       = '0;
                    illegal_c = 1'b1;
                end
            end
            ST_HALT: halted_c = 1'b1;
            default: ret = 1'b1;
        endcase

        if (jump) begin
            // next state already chosen above
        end else if (ret) begin
            state_d = ST_FETCH;
            phase_d = 3'd1;
        end else if (state_q == ST_HALT) begin
            phase_d = phase_q;
        end else if ((ctl.read || ctl.write) && !mem_ready) begin
            phase_d = phase_q;
        end else begin
            phase_d = phase_q + 3'd1;
        end

        if (!rst_n) begin
            ctl       = '0;
            halted_c  = 1'b0;
            illegal_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            phase_q <= 3'd1;
            op_q    <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
        end
    end

    assign oe_ms     = ctl.oe_ms;
    assign oe_ir     = ctl.oe_ir;
    assign oe_pc     = ctl.oe_pc;
    assign oe_alureg = ctl.oe_alureg;
    assign oe_d      = ctl.oe_d;
    assign we_mar    = ctl.we_mar;
    assign we_ir     = ctl.we_ir;
    assign we_pc     = ctl.we_pc;
    assign we_alureg = ctl.we_alureg;
    assign we_d      = ctl.we_d;
    assign func      = ctl.func;
    assign read      = ctl.read;
    assign write     = ctl.write;
    assign state     = state_q;
    assign phase     = phase_q;
    assign halted    = halted_c;
    assign illegal   = illegal_c;

endmodule

// File: tb/tb_control_sequencer.sv
// Purpose: directed self-checking bench for control_sequencer (4-register and 3-register builds in lockstep).
// Latency: inputs driven 2 ns after posedge, outputs sampled 1 ns later (mid-cycle).
// Backpressure: mem_ready is driven low explicitly to create wait states.
module tb_control_sequencer;

    localparam logic [11:0] S_OE_MS  = 12'h800;
    localparam logic [11:0] S_OE_IR  = 12'h400;
    localparam logic [11:0] S_OE_PC  = 12'h200;
    localparam logic [11:0] S_OE_ALU = 12'h100;
    localparam logic [11:0] S_WE_MAR = 12'h080;
    localparam logic [11:0] S_WE_IR  = 12'h040;
    localparam logic [11:0] S_WE_PC  = 12'h020;
    localparam logic [11:0] S_WE_ALU = 12'h010;
    localparam logic [11:0] S_RD     = 12'h008;
    localparam logic [11:0] S_WR     = 12'h004;
    localparam logic [11:0] S_HALT   = 12'h002;
    localparam logic [11:0] S_ILL    = 12'h001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] opcode;
    logic [1:0] reg_sel;
    logic       zero;
    logic       mem_ready;

    logic       oe_ms, oe_ir, oe_pc, oe_alureg, we_mar, we_ir, we_pc, we_alureg;
    logic       read, write, halted, illegal;
    logic [3:0] oe_d, we_d;
    logic [1:0] func, state;
    logic [2:0] phase;

    logic       oe_ms3, oe_ir3, oe_pc3, oe_alureg3, we_mar3, we_ir3, we_pc3, we_alureg3;
    logic       read3, write3, halted3, illegal3;
    logic [2:0] oe_d3, we_d3;
    logic [1:0] func3, state3;
    logic [2:0] phase3;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    control_sequencer #(.NUM_REGS(4), .SEL_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .reg_sel(reg_sel), .zero(zero),
        .mem_ready(mem_ready), .oe_ms(oe_ms), .oe_ir(oe_ir), .oe_pc(oe_pc),
        .oe_alureg(oe_alureg), .oe_d(oe_d), .we_mar(we_mar), .we_ir(we_ir), .we_pc(we_pc),
        .we_alureg(we_alureg), .we_d(we_d), .func(func), .read(read), .write(write),
        .state(state), .phase(phase), .halted(halted), .illegal(illegal)
    );

    control_sequencer #(.NUM_REGS(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .reg_sel(reg_sel), .zero(zero),
        .mem_ready(mem_ready), .oe_ms(oe_ms3), .oe_ir(oe_ir3), .oe_pc(oe_pc3),
        .oe_alureg(oe_alureg3), .oe_d(oe_d3), .we_mar(we_mar3), .we_ir(we_ir3), .we_pc(we_pc3),
        .we_alureg(we_alureg3), .we_d(we_d3), .func(func3), .read(read3), .write(write3),
        .state(state3), .phase(phase3), .halted(halted3), .illegal(illegal3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Whole-output snapshot of the 4-register build against one expected step.
    task automatic exp_cyc(input string tag, input logic [1:0] st, input logic [2:0] ph,
                           input logic [11:0] sv, input logic [3:0] wd, input logic [3:0] od,
                           input logic [1:0] fn);
        check(tag,
              {5'd0, state, phase, oe_ms, oe_ir, oe_pc, oe_alureg, we_mar, we_ir, we_pc,
               we_alureg, read, write, halted, illegal, we_d, oe_d, func},
              {5'd0, st, ph, sv, wd, od, fn});
    endtask

    // Runs FETCH T1..T5 from a settled T1, with nwait wait states at T2, and
    // returns settled at EXECUTE T1.
    task automatic do_fetch(input logic [3:0] op, input logic [1:0] sel, input int nwait);
        exp_cyc("fetch_t1", 2'b00, 3'd1, S_OE_PC | S_WE_MAR, 4'h0, 4'h0, 2'b00);
        cyc();
        for (int i = 0; i < nwait; i++) begin
            mem_ready = 1'b0;
            #1;
            exp_cyc("fetch_t2_wait", 2'b00, 3'd2, S_RD | S_OE_MS, 4'h0, 4'h0, 2'b00);
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        exp_cyc("fetch_t2", 2'b00, 3'd2, S_RD | S_OE_MS | S_WE_IR, 4'h0, 4'h0, 2'b00);
        cyc();
        opcode  = op;
        reg_sel = sel;
        #1;
        exp_cyc("fetch_t3", 2'b00, 3'd3, S_OE_PC | S_WE_ALU, 4'h0, 4'h0, 2'b01);
        cyc();
        exp_cyc("fetch_t4", 2'b00, 3'd4, S_OE_ALU | S_WE_PC, 4'h0, 4'h0, 2'b00);
        cyc();
        exp_cyc("fetch_t5", 2'b00, 3'd5, 12'h000, 4'h0, 4'h0, 2'b00);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = 4'd0;
        reg_sel   = 2'd2;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // Reset: FETCH T1 registered, all strobes forced low.
        cyc();
        exp_cyc("reset", 2'b00, 3'd1, 12'h000, 4'h0, 4'h0, 2'b00);
        cyc();
        rst_n = 1'b1;
        #1;

        // CLEAR D2: writes 0100 at EXECUTE T2, FETCH T1 again on cycle 9.
        do_fetch(4'd0, 2'd2, 0);
        exp_cyc("clr_e1", 2'b01, 3'd1, S_WE_ALU, 4'h0, 4'h0, 2'b00);
        cyc();
        exp_cyc("clr_e2", 2'b01, 3'd2, S_OE_ALU, 4'b0100, 4'h0, 2'b00);
        cyc();
        exp_cyc("clr_e3", 2'b01, 3'd3, 12'h000, 4'h0, 4'h0, 2'b00);
        cyc();

        // INC D3 with three fetch wait states; out of range for the 3-register build.
        do_fetch(4'd1, 2'd3, 3);
        exp_cyc("inc_e1", 2'b01, 3'd1, S_WE_ALU, 4'h0, 4'b1000, 2'b01);
        check("d3_ill_e1", {31'd0, illegal3}, 32'd1);
        check("d3_wd_e1", {29'd0, we_d3}, 32'd0);
        check("d3_od_e1", {29'd0, oe_d3}, 32'd0);
        cyc();
        exp_cyc("inc_e2", 2'b01, 3'd2, S_OE_ALU, 4'b1000, 4'h0, 2'b00);
        check("d3_ill_e2", {31'd0, illegal3}, 32'd1);
        check("d3_wd_e2", {29'd0, we_d3}, 32'd0);
        cyc();
        exp_cyc("inc_e3", 2'b01, 3'd3, 12'h000, 4'h0, 4'h0, 2'b00);
        check("d3_ill_ret", {31'd0, illegal3}, 32'd0);
        cyc();
        check("d3_next_t1", {26'd0, state3, phase3, oe_pc3}, {26'd0, 2'b00, 3'd1, 1'b1});

        // BUZ not taken, then taken.
        do_fetch(4'd5, 2'd0, 0);
        exp_cyc("buz_nz_e1", 2'b01, 3'd1, S_OE_IR, 4'h0, 4'h0, 2'b00);
        cyc();
        exp_cyc("buz_nz_e2", 2'b01, 3'd2, 12'h000, 4'h0, 4'h0, 2'b00);
        cyc();
        do_fetch(4'd5, 2'd0, 0);
        zero = 1'b1;
        #1;
        exp_cyc("buz_z_e1", 2'b01, 3'd1, S_OE_IR | S_WE_PC, 4'h0, 4'h0, 2'b00);
        cyc();
        zero = 1'b0;
        #1;
        exp_cyc("buz_z_e2", 2'b01, 3'd2, 12'h000, 4'h0, 4'h0, 2'b00);
        cyc();

        // ADD into D1.
        do_fetch(4'd2, 2'd1, 0);
        exp_cyc("add_e1", 2'b01, 3'd1, S_OE_IR | S_WE_ALU, 4'h0, 4'h0, 2'b10);
        cyc();
        exp_cyc("add_e2", 2'b01, 3'd2, S_OE_ALU, 4'b0010, 4'h0, 2'b00);
        cyc();
        exp_cyc("add_e3", 2'b01, 3'd3, 12'h000, 4'h0, 4'h0, 2'b00);
        cyc();

        // LOAD D0 with one wait state.
        do_fetch(4'd6, 2'd0, 0);
        exp_cyc("ld_e1", 2'b01, 3'd1, S_OE_IR | S_WE_MAR, 4'h0, 4'h0, 2'b00);
        cyc();
        mem_ready = 1'b0;
        #1;
        exp_cyc("ld_e2_wait", 2'b01, 3'd2, S_RD | S_OE_MS, 4'h0, 4'h0, 2'b00);
        cyc();
        mem_ready = 1'b1;
        #1;
        exp_cyc("ld_e2", 2'b01, 3'd2, S_RD | S_OE_MS, 4'b0001, 4'h0, 2'b00);
        cyc();
        exp_cyc("ld_e3", 2'b01, 3'd3, 12'h000, 4'h0, 4'h0, 2'b00);
        cyc();

        // Undefined opcode 9.
        do_fetch(4'd9, 2'd0, 0);
        exp_cyc("ill_e1", 2'b01, 3'd1, S_ILL, 4'h0, 4'h0, 2'b00);
        cyc();
        exp_cyc("ill_e2", 2'b01, 3'd2, 12'h000, 4'h0, 4'h0, 2'b00);
        cyc();

        // STORE D1 stalled, reset pulsed during the wait.
        do_fetch(4'd7, 2'd1, 0);
        exp_cyc("st_e1", 2'b01, 3'd1, S_OE_IR | S_WE_MAR, 4'h0, 4'h0, 2'b00);
        cyc();
        mem_ready = 1'b0;
        #1;
        exp_cyc("st_e2_wait", 2'b01, 3'd2, S_WR, 4'h0, 4'b0010, 2'b00);
        cyc();
        exp_cyc("st_e2_hold", 2'b01, 3'd2, S_WR, 4'h0, 4'b0010, 2'b00);
        rst_n = 1'b0;
        #1;
        exp_cyc("st_rst_low", 2'b01, 3'd2, 12'h000, 4'h0, 4'h0, 2'b00);
        cyc();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        #1;

        // HALT: 20 cycles of halted with inputs wiggling, then reset.
        do_fetch(4'd8, 2'd0, 0);
        exp_cyc("halt_e1", 2'b01, 3'd1, 12'h000, 4'h0, 4'h0, 2'b00);
        cyc();
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            zero      = i[1];
            #1;
            exp_cyc("halted", 2'b10, 3'd1, S_HALT, 4'h0, 4'h0, 2'b00);
            cyc();
        end
        mem_ready = 1'b1;
        zero      = 1'b0;
        rst_n     = 1'b0;
        #1;
        exp_cyc("halt_rst_low", 2'b10, 3'd1, 12'h000, 4'h0, 4'h0, 2'b00);
        cyc();
        rst_n = 1'b1;
        #1;
        exp_cyc("halt_exit_t1", 2'b00, 3'd1, S_OE_PC | S_WE_MAR, 4'h0, 4'h0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
